// File: rtl/brisc_pkg.sv
// Shared brisc core types and sizes used by the memory-side blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package brisc_pkg;

    localparam int ADDRESS_BITS     = 32;
    localparam int CACHE_LINE_LEN   = 512;
    localparam int BYTE_LEN         = 8;
    // Byte offset bits inside one cache line (64-byte line -> 6).
    localparam int LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN / BYTE_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single main-memory line port between icache and dcache, round-robin on ties.
// Latency: request in IDLE at cycle 0 -> mem_req_valid cycle 1 -> resp_valid cycle 3 with 1-cycle memory.
// Backpressure: holds mem_req_* stable until mem_req_ready; one transaction in flight, others wait for IDLE.
//
// Ports: clk/reset (async, active-high); i_req/i_addr -> i_resp_valid/i_resp_data (icache fills);
// d_req/d_we/d_addr/d_wdata -> d_resp_valid/d_resp_data (dcache fills and writebacks);
// mem_req_valid/ready + mem_we/addr/wdata to memory, mem_resp_valid/data back; err_timeout sticky.
module mem_arbiter
    import brisc_pkg::*;
#(
    parameter int ADDR_W  = ADDRESS_BITS,
    parameter int LINE_W  = CACHE_LINE_LEN,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp_valid,
    output logic [LINE_W-1:0] i_resp_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp_valid,
    output logic [LINE_W-1:0] d_resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

    arb_state_e        state;
    requester_e        owner;
    requester_e        rr_last;
    logic [CNT_W-1:0]  wait_cnt;
    logic [LINE_W-1:0] resp_q;

    logic              grant_any;
    requester_e        grant_id;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        grant_any = i_req | d_req;
        grant_id  = (i_req && d_req) ? ((rr_last == REQ_I) ? REQ_D : REQ_I)
                                     : (d_req ? REQ_D : REQ_I);
    end

    // Both caches see the same response register; only resp_valid selects the consumer.
    assign i_resp_data = resp_q;
    assign d_resp_data = resp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= REQ_I;
            rr_last       <= REQ_I;
            wait_cnt      <= '0;
            resp_q        <= '0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            i_resp_valid  <= 1'b0;
            d_resp_valid  <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner         <= grant_id;
                        rr_last       <= grant_id;
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                        if (grant_id == REQ_D) begin
                            mem_addr  <= d_addr & ~OFFSET_MASK;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr  <= i_addr & ~OFFSET_MASK;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter saturates at TIMEOUT; the flag stays set until reset.
                    if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    if (mem_resp_valid) begin
                        resp_q       <= mem_resp_data;
                        i_resp_valid <= (owner == REQ_I);
                        d_resp_valid <= (owner == REQ_D);
                        state        <= RESP;
                    end
                end
                RESP: begin
                    i_resp_valid <= 1'b0;
                    d_resp_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 512;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_resp_valid;
    logic [LINE_W-1:0] i_resp_data;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic              d_resp_valid;
    logic [LINE_W-1:0] d_resp_data;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp_valid = 1'b0;
    logic [LINE_W-1:0] mem_resp_data = '0;
    logic              err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_resp_valid  (i_resp_valid),
        .i_resp_data   (i_resp_data),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_resp_valid  (d_resp_valid),
        .d_resp_data   (d_resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    logic [LINE_W-1:0] pat_a5, pat_wr, pat_i2, pat_d3, pat_late;
    int acc_cyc[2];
    logic [ADDR_W-1:0] acc_addr[2];
    int n_acc;

    initial begin
        pat_a5   = {64{8'hA5}};
        pat_wr   = {16{32'hDEAD_BEEF}};
        pat_i2   = {64{8'h3C}};
        pat_d3   = {32{16'h1234}};
        pat_late = {64{8'h77}};

        do_reset();

        // Reset state
        chk("rst_mem_req_valid", LINE_W'(mem_req_valid), '0);
        chk("rst_i_resp_valid", LINE_W'(i_resp_valid), '0);
        chk("rst_d_resp_valid", LINE_W'(d_resp_valid), '0);
        chk("rst_mem_we", LINE_W'(mem_we), '0);
        chk("rst_mem_addr", LINE_W'(mem_addr), '0);
        chk("rst_err", LINE_W'(err_timeout), '0);

        // Single icache read, 1-cycle memory
        i_req = 1'b1; i_addr = 32'h0000_1004; mem_req_ready = 1'b1;   // cycle 0
        tick();                                                         // cycle 1
        chk("i1_req_valid", LINE_W'(mem_req_valid), 1);
        chk("i1_addr", LINE_W'(mem_addr), LINE_W'(32'h0000_1000));
        chk("i1_we", LINE_W'(mem_we), '0);
        tick();                                                         // cycle 2
        chk("i1_req_dropped", LINE_W'(mem_req_valid), '0);
        mem_resp_valid = 1'b1; mem_resp_data = pat_a5;
        tick();                                                         // cycle 3
        mem_resp_valid = 1'b0;
        chk("i1_resp_valid", LINE_W'(i_resp_valid), 1);
        chk("i1_resp_data", i_resp_data, pat_a5);
        chk("i1_d_quiet", LINE_W'(d_resp_valid), '0);
        i_req = 1'b0;
        tick();                                                         // cycle 4
        chk("i1_resp_pulse", LINE_W'(i_resp_valid), '0);

        // Tie after reset: D first, then second tie goes to I
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_5000;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2040; d_wdata = pat_wr;
        tick();
        chk("tie_d_addr", LINE_W'(mem_addr), LINE_W'(32'h0000_2040));
        chk("tie_d_we", LINE_W'(mem_we), 1);
        chk("tie_d_wdata", mem_wdata, pat_wr);
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = pat_i2;
        tick();
        mem_resp_valid = 1'b0;
        chk("tie_d_resp", LINE_W'(d_resp_valid), 1);
        chk("tie_i_quiet", LINE_W'(i_resp_valid), '0);
        d_we = 1'b0;                                  // d_req stays high: new request, ties with I
        tick();                                       // IDLE
        tick();                                       // ISSUE
        chk("tie2_i_valid", LINE_W'(mem_req_valid), 1);
        chk("tie2_i_addr", LINE_W'(mem_addr), LINE_W'(32'h0000_5000));
        chk("tie2_i_we", LINE_W'(mem_we), '0);
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        chk("tie2_i_resp", LINE_W'(i_resp_valid), 1);
        chk("tie2_i_data", i_resp_data, pat_i2);
        chk("tie2_d_quiet", LINE_W'(d_resp_valid), '0);
        i_req = 1'b0; d_req = 1'b0;
        tick();                                       // IDLE, nothing pending

        // Backpressure: ready low for 5 cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3010; mem_req_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("bp_valid_held", LINE_W'(mem_req_valid), 1);
            chk("bp_addr_held", LINE_W'(mem_addr), LINE_W'(32'h0000_3000));
        end
        tick();                                       // cycle 6
        chk("bp_valid_c6", LINE_W'(mem_req_valid), 1);
        mem_req_ready = 1'b1;
        tick();                                       // cycle 7, WAIT
        mem_resp_valid = 1'b1; mem_resp_data = pat_d3;
        tick();                                       // cycle 8 = 3 + 5
        mem_resp_valid = 1'b0;
        chk("bp_resp_c8", LINE_W'(d_resp_valid), 1);
        chk("bp_resp_data", d_resp_data, pat_d3);
        d_req = 1'b0;
        tick();

        // Timeout: memory silent well past TIMEOUT, then a late response
        i_req = 1'b1; i_addr = 32'h0000_4000;
        tick();                                       // ISSUE
        tick();                                       // WAIT, count 0
        for (int k = 1; k < TIMEOUT; k++) tick();     // count TIMEOUT-1
        chk("to_err_early", LINE_W'(err_timeout), '0);
        repeat (3) tick();
        chk("to_err_set", LINE_W'(err_timeout), 1);
        chk("to_no_resp", LINE_W'(i_resp_valid), '0);
        mem_resp_valid = 1'b1; mem_resp_data = pat_late;
        tick();
        mem_resp_valid = 1'b0;
        chk("to_late_resp", LINE_W'(i_resp_valid), 1);
        chk("to_late_data", i_resp_data, pat_late);
        i_req = 1'b0;
        tick();
        chk("to_err_sticky", LINE_W'(err_timeout), 1);

        // Reset in WAIT, mid-cycle
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_6000; d_wdata = pat_wr;
        tick();                                       // ISSUE
        tick();                                       // WAIT
        d_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rw_req_valid", LINE_W'(mem_req_valid), '0);
        chk("rw_err_clr", LINE_W'(err_timeout), '0);
        chk("rw_mem_we", LINE_W'(mem_we), '0);
        chk("rw_mem_addr", LINE_W'(mem_addr), '0);
        tick();
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = pat_a5;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rw_stray_d", LINE_W'(d_resp_valid), '0);
            chk("rw_stray_i", LINE_W'(i_resp_valid), '0);
        end
        mem_resp_valid = 1'b0;

        // Back-to-back dcache reads with a 1-cycle memory
        n_acc = 0;
        acc_cyc[0] = -1; acc_cyc[1] = -1;
        acc_addr[0] = '0; acc_addr[1] = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_7000;
        mem_resp_valid = 1'b1; mem_resp_data = pat_d3;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (mem_req_valid && n_acc < 2) begin
                acc_cyc[n_acc]  = c;
                acc_addr[n_acc] = mem_addr;
                n_acc++;
                if (n_acc == 2) d_req = 1'b0;
            end
            if (d_resp_valid) d_addr = 32'h0000_7080;
        end
        mem_resp_valid = 1'b0;
        chk("b2b_accepts", LINE_W'(n_acc), 2);
        chk("b2b_gap", LINE_W'(acc_cyc[1] - acc_cyc[0]), 4);
        chk("b2b_addr0", LINE_W'(acc_addr[0]), LINE_W'(32'h0000_7000));
        chk("b2b_addr1", LINE_W'(acc_addr[1]), LINE_W'(32'h0000_7080));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory line port between the instruction-cache and data-cache miss/writeback paths of the brisc core.
- Accepts one line-sized request at a time from either cache and arbitrates round-robin on ties.
- Drives a valid/ready request and a response handshake to memory, and returns the line or write-ack to the granted cache.
- Flags a sticky error when memory exceeds a response-time limit.

Parameters:
- ADDR_W, 32, address width (matches ADDRESS_BITS).
- LINE_W, 512, cache line width in bits (matches CACHE_LINE_LEN).
- TIMEOUT, 255, max cycles in WAIT before err_timeout sets; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  icache read request; held until i_resp_valid.
- i_addr  in  ADDR_W  icache line address.
- i_resp_valid  out  1  one-cycle pulse; i_resp_data valid.
- i_resp_data  out  LINE_W  line returned to icache.
- d_req  in  1  dcache request; held until d_resp_valid.
- d_we  in  1  1 = line writeback, 0 = line fill.
- d_addr  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  writeback line.
- d_resp_valid  out  1  one-cycle pulse; read data or write ack.
- d_resp_data  out  LINE_W  line returned to dcache (don't-care on write).
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  line-aligned address.
- mem_wdata  out  LINE_W  write line.
- mem_resp_valid  in  1  one-cycle response/ack from memory.
- mem_resp_data  in  LINE_W  read line.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (async, any state):
  - state = IDLE; rr_last = I; all *_valid outputs, mem_we and err_timeout = 0; data/address registers = 0.
  - Any in-flight memory transaction is abandoned; memory shares the same reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not rr_last. After reset, the first tie therefore goes to D.
  - On grant: latch requester id, address with bits [5:0] forced to 0, we (0 for I) and wdata; update rr_last; go to ISSUE next cycle.
- ISSUE:
  - mem_req_valid = 1, with mem_addr, mem_we and mem_wdata from the latched registers (stable while waiting for ready).
  - On mem_req_ready, go to WAIT and clear the timeout counter.
- WAIT:
  - Counter increments each cycle.
  - On mem_resp_valid, capture mem_resp_data into the response register and go to RESP.
  - When the counter reaches TIMEOUT, set err_timeout (cleared only by reset) and keep waiting.
  - mem_resp_valid is ignored in every state other than WAIT.
- RESP:
  - Assert the granted requester's resp_valid for exactly one cycle, with data from the register; return to IDLE.
  - The ungranted requester's resp_valid stays 0.
- Latency:
  - Request seen in IDLE at cycle 0 gives mem_req_valid at cycle 1.
  - With ready at cycle 1 and response at cycle 2, resp_valid is at cycle 3.
  - Every extra memory wait cycle adds 1.
- Requester rules:
  - Requesters must hold req/addr/we/wdata stable until their resp_valid.
  - req still high in the cycle after resp_valid is a new request.
  - Changes to an ungranted requester's inputs mid-transaction do not affect the transaction in flight.
- Non-preemptive: a request arriving during ISSUE/WAIT/RESP waits for IDLE.
- Back-to-back requests: IDLE always costs one cycle, so at most one transaction per 4 cycles.

Decomposition:
- Add to brisc_pkg:
  - arb_state_e {IDLE, ISSUE, WAIT, RESP} as logic [1:0].
  - requester_e {REQ_I, REQ_D} as logic.
  - LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN/BYTE_LEN) = 6.
- No sub-module; the round-robin pick is a two-line expression inside the block.

Test Plan:
- Single icache read: i_req, i_addr=0x00001004, ready held high, memory responds 1 cycle after accept with 0xA5.. → mem_addr=0x00001000, mem_we=0; i_resp_valid at cycle 3 with the line; d_resp_valid stays 0.
- Tie after reset: i_req and d_req both high at cycle 0 with d_we=1, d_addr=0x2040 → D granted first, mem_we=1, mem_wdata=d_wdata. I issues after d_resp_valid; then a second tie grants I.
- Backpressure: mem_req_ready low for 5 cycles → mem_req_valid and address/data held stable for all 5 cycles; response latency grows by 5.
- Timeout: no mem_resp_valid for TIMEOUT+2 cycles → err_timeout rises at count TIMEOUT and stays high. A late response still completes the transaction; err_timeout clears only on reset.
- Reset in WAIT: assert reset asynchronously mid-cycle → all outputs 0 immediately and state IDLE. A stray mem_resp_valid after reset produces no resp_valid.
- Back-to-back: d_req held high across two transactions with different addresses, i_req low → two accepts exactly 4 cycles apart (1-cycle memory).
